// File: rtl/spi_regbank_n_if.sv
// SPI pin bundle for spi_regbank_n: active-low chip select, serial data in,
// serial readback out.
interface spi_regbank_n_if;
    logic CS;
    logic COPI;
    logic CIPO;

    modport master (output CS, output COPI, input CIPO);
    modport slave  (input CS, input COPI, output CIPO);
endinterface

// File: rtl/spi_regbank_n.sv
// SCK-clocked SPI-slave register bank with readback, read-only status mapping,
// write strobes and sticky address-error flag. Optional macro: SPI_REGBANK_BURST_EN.
module spi_regbank_n #(
    parameter int NUM_REGS = 6,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10,
    parameter logic [31:0] RO_MASK = 32'h0000_0030,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VALUES = '0
) (
    input  logic                       SCK,
    input  logic                       rst,
    spi_regbank_n_if.slave             bus,
    input  logic [NUM_REGS*DATA_W-1:0] status_in,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       err_addr
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int SH_W = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W + 1);

    logic [CNT_W-1:0]  bit_cnt_r;
    logic [SH_W-1:0]   shift_r;
    logic [DATA_W-1:0] rd_shift_r;
    logic              rd_active_r;
    logic              rw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] mem_r [NUM_REGS];
`ifdef SPI_REGBANK_BURST_EN
    logic              rd_bad_r;
`endif

    logic              hdr_s;
    logic              last_s;
    logic              hdr_rw_s;
    logic [ADDR_W-1:0] hdr_addr_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_val_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              rd_ok_s;
    logic              wr_ok_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS);
    endfunction

    function automatic logic is_ro(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit = (a == ADDR_W'(i)) ? RO_MASK[i] : hit;
        end
        return hit;
    endfunction

    // Frame decode: header/last-bit detection, readback source selection, write data.
    always_comb begin
        hdr_s       = (bit_cnt_r == HDR_LAST);
        last_s      = (bit_cnt_r == FRM_LAST);
        // At the header edge the shifter holds R/W plus all but the last address bit.
        hdr_rw_s    = shift_r[ADDR_W-1];
        hdr_addr_s  = {shift_r[ADDR_W-2:0], bus.COPI};
        next_addr_s = addr_r + ADDR_W'(1'b1);
        rd_addr_s   = hdr_s ? hdr_addr_s : next_addr_s;
        rd_ok_s     = in_range(rd_addr_s);
        wr_ok_s     = in_range(addr_r) && !is_ro(addr_r);
        wr_data_s   = {shift_r[DATA_W-2:0], bus.COPI};
        rd_val_s    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_val_s = (rd_addr_s == ADDR_W'(i))
                     ? (RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : mem_r[i])
                     : rd_val_s;
        end
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = mem_r[i];
        end
    end

    // Readback is forced low outside the read data phase and while deselected.
    assign bus.CIPO = rd_active_r & ~bus.CS & rd_shift_r[DATA_W-1];

    // Frame sequencing, header latch, readback load and register commit.
    always_ff @(posedge SCK or posedge rst) begin
        if (rst) begin
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            rd_shift_r  <= '0;
            rd_active_r <= 1'b0;
            rw_r        <= 1'b0;
            addr_r      <= '0;
            wr_stb      <= 1'b0;
            wr_addr     <= '0;
            err_addr    <= 1'b0;
`ifdef SPI_REGBANK_BURST_EN
            rd_bad_r    <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= RST_VALUES[i*DATA_W +: DATA_W];
            end
        end else if (bus.CS) begin
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            rd_shift_r  <= '0;
            rd_active_r <= 1'b0;
            wr_stb      <= 1'b0;
`ifdef SPI_REGBANK_BURST_EN
            rd_bad_r    <= 1'b0;
`endif
        end else begin
            wr_stb     <= 1'b0;
            shift_r    <= {shift_r[SH_W-2:0], bus.COPI};
            bit_cnt_r  <= bit_cnt_r + CNT_W'(1'b1);
            rd_shift_r <= {rd_shift_r[DATA_W-2:0], 1'b0};
            if (hdr_s) begin
                rw_r   <= hdr_rw_s;
                addr_r <= hdr_addr_s;
                if (!hdr_rw_s) begin
                    rd_active_r <= 1'b1;
                    rd_shift_r  <= rd_ok_s ? rd_val_s : '0;
                    if (!rd_ok_s) begin
                        err_addr <= 1'b1;
                    end
                end
`ifdef SPI_REGBANK_BURST_EN
                rd_bad_r <= 1'b0;
`endif
            end
`ifdef SPI_REGBANK_BURST_EN
            // A prefetched out-of-range burst word only counts once the host clocks into it.
            if (rd_active_r && rd_bad_r && (bit_cnt_r == DATA_FIRST)) begin
                err_addr <= 1'b1;
            end
`endif
            if (last_s) begin
                shift_r <= '0;
                if (rw_r) begin
                    if (wr_ok_s) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_r == ADDR_W'(i)) begin
                                mem_r[i] <= wr_data_s;
                            end
                        end
                        wr_stb  <= 1'b1;
                        wr_addr <= addr_r;
                    end else begin
                        err_addr <= 1'b1;
                    end
                end
`ifdef SPI_REGBANK_BURST_EN
                bit_cnt_r <= DATA_FIRST;
                addr_r    <= next_addr_s;
                if (!rw_r) begin
                    rd_shift_r <= rd_ok_s ? rd_val_s : '0;
                    rd_bad_r   <= !rd_ok_s;
                end
`else
                bit_cnt_r   <= '0;
                rd_active_r <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spi_regbank_n.sv
// Self-checking bench for spi_regbank_n: directed table, hand sequences for
// abort/reset/burst, and random frames against a frame-level reference model.
module tb_spi_regbank_n;
    localparam int NR = 6;
    localparam logic [5:0] RO = 6'b110000;

    logic        SCK = 1'b0;
    logic        rst;
    logic [59:0] status_in;
    logic [59:0] regs_flat;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic        err_addr;

    spi_regbank_n_if bus();

    spi_regbank_n #(
        .NUM_REGS(NR), .ADDR_W(4), .DATA_W(10),
        .RO_MASK(32'h0000_0030), .RST_VALUES(60'h0)
    ) dut (
        .SCK(SCK), .rst(rst), .bus(bus), .status_in(status_in),
        .regs_flat(regs_flat), .wr_stb(wr_stb), .wr_addr(wr_addr), .err_addr(err_addr)
    );

    always #5 SCK = ~SCK;

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0] ref_regs [NR];
    logic [9:0] ref_status [NR];
    logic       ref_err;
    logic [3:0] ref_wa;

    always_comb begin
        status_in = '0;
        for (int i = 0; i < NR; i++) status_in[i*10 +: 10] = ref_status[i];
    end

    typedef struct {
        logic       rw;
        logic [3:0] addr;
        logic [9:0] data;
        logic [9:0] exp_rd;
        int         exp_stb;
        logic       exp_err;
        logic [3:0] exp_wa;
        logic [9:0] exp_reg;
    } vec_t;
    vec_t vecs [13];

    function automatic logic [59:0] ref_flat();
        logic [59:0] f;
        for (int i = 0; i < NR; i++) f[i*10 +: 10] = ref_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) ref_regs[i] = 10'h000;
        ref_err = 1'b0;
        ref_wa = 4'h0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full frame with CS low, then one CS-high edge; CIPO sampled just before each edge.
    task automatic do_frame(input logic rw, input logic [3:0] a, input logic [9:0] d,
                            output logic [9:0] rdata, output int stb_cnt,
                            output int stb_pos, output logic stray);
        logic [14:0] f;
        f = {rw, a, d};
        rdata = 10'h000;
        stb_cnt = 0;
        stb_pos = 0;
        stray = 1'b0;
        bus.CS = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            bus.COPI = f[15-k];
            if (k >= 6) rdata = {rdata[8:0], bus.CIPO};
            else stray = stray | bus.CIPO;
            @(posedge SCK); #1;
            if (wr_stb) begin
                stb_cnt++;
                stb_pos = k;
            end
        end
`ifndef SPI_REGBANK_BURST_EN
        stray = stray | bus.CIPO;
`endif
        bus.CS = 1'b1;
        bus.COPI = 1'b0;
        #1;
        stray = stray | bus.CIPO;
        @(posedge SCK); #1;
        if (wr_stb) stb_cnt++;
        stray = stray | bus.CIPO;
    endtask

    task automatic run_frame(input logic rw, input logic [3:0] a, input logic [9:0] d,
                             output logic [9:0] rdata, output int stb_cnt);
        logic in_rng, ro, stray;
        logic [9:0] exp_rd;
        int exp_stb, stb_pos;
        in_rng = (a < 4'd6);
        ro = in_rng && RO[a[2:0]];
        exp_rd = 10'h000;
        exp_stb = 0;
        if (!rw) begin
            if (!in_rng) ref_err = 1'b1;
            else exp_rd = ro ? ref_status[a[2:0]] : ref_regs[a[2:0]];
        end else if (in_rng && !ro) begin
            ref_regs[a[2:0]] = d;
            ref_wa = a;
            exp_stb = 1;
        end else begin
            ref_err = 1'b1;
        end
        do_frame(rw, a, d, rdata, stb_cnt, stb_pos, stray);
        check("regs_flat", regs_flat, ref_flat());
        check("err_addr", err_addr, ref_err);
        check("wr_addr", wr_addr, ref_wa);
        check("wr_stb count", stb_cnt, exp_stb);
        check("wr_stb edge", stb_pos, (exp_stb != 0) ? 15 : 0);
        check("CIPO idle", stray, 1'b0);
        if (!rw) check("read data", rdata, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rd;
        int stb;
        logic [34:0] stream;
        logic [3:0] ra;

        vecs[0]  = '{1'b1, 4'd1, 10'h155, 10'h000, 1, 1'b0, 4'd1, 10'h155};
        vecs[1]  = '{1'b0, 4'd1, 10'h000, 10'h155, 0, 1'b0, 4'd1, 10'h155};
        vecs[2]  = '{1'b1, 4'd3, 10'h2C3, 10'h000, 1, 1'b0, 4'd3, 10'h2C3};
        vecs[3]  = '{1'b0, 4'd3, 10'h3FF, 10'h2C3, 0, 1'b0, 4'd3, 10'h2C3};
        vecs[4]  = '{1'b0, 4'd2, 10'h000, 10'h0F0, 0, 1'b0, 4'd3, 10'h0F0};
        vecs[5]  = '{1'b0, 4'd4, 10'h000, 10'h2AA, 0, 1'b0, 4'd3, 10'h000};
        vecs[6]  = '{1'b0, 4'd5, 10'h000, 10'h133, 0, 1'b0, 4'd3, 10'h000};
        vecs[7]  = '{1'b1, 4'd9, 10'h3FF, 10'h000, 0, 1'b1, 4'd3, 10'h000};
        vecs[8]  = '{1'b1, 4'd4, 10'h123, 10'h000, 0, 1'b1, 4'd3, 10'h000};
        vecs[9]  = '{1'b0, 4'd9, 10'h000, 10'h000, 0, 1'b1, 4'd3, 10'h000};
        vecs[10] = '{1'b1, 4'd0, 10'h3FF, 10'h000, 1, 1'b1, 4'd0, 10'h3FF};
        vecs[11] = '{1'b0, 4'd0, 10'h000, 10'h3FF, 0, 1'b1, 4'd0, 10'h3FF};
        vecs[12] = '{1'b1, 4'd5, 10'h155, 10'h000, 0, 1'b1, 4'd0, 10'h000};

        bus.CS = 1'b1;
        bus.COPI = 1'b0;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < NR; i++) ref_status[i] = 10'h3A5;
        ref_status[4] = 10'h2AA;
        ref_status[5] = 10'h133;
        repeat (2) @(posedge SCK);
        #1 rst = 1'b0;
        check("reset regs_flat", regs_flat, 60'h0);
        check("reset CIPO", bus.CIPO, 1'b0);
        check("reset err_addr", err_addr, 1'b0);
        check("reset wr_stb", wr_stb, 1'b0);
        check("reset wr_addr", wr_addr, 4'h0);

        // Abort a write after 7 bits, one CS-high edge, then a clean write.
        stb = 0;
        stream = {20'h0, 15'b1_0011_0110101010};
        bus.CS = 1'b0;
        for (int k = 14; k >= 8; k--) begin
            bus.COPI = stream[k];
            @(posedge SCK); #1;
            if (wr_stb) stb++;
        end
        bus.CS = 1'b1;
        @(posedge SCK); #1;
        if (wr_stb) stb++;
        check("abort wr_stb", stb, 0);
        check("abort regs_flat", regs_flat, ref_flat());
        run_frame(1'b1, 4'd2, 10'h0F0, rd, stb);

        for (int i = 0; i < 13; i++) begin
            run_frame(vecs[i].rw, vecs[i].addr, vecs[i].data, rd, stb);
            check($sformatf("vec%0d stb", i), stb, vecs[i].exp_stb);
            check($sformatf("vec%0d err", i), err_addr, vecs[i].exp_err);
            check($sformatf("vec%0d wr_addr", i), wr_addr, vecs[i].exp_wa);
            if (!vecs[i].rw) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            if (vecs[i].addr < 4'd6)
                check($sformatf("vec%0d reg", i), regs_flat[vecs[i].addr*10 +: 10], vecs[i].exp_reg);
        end

        // Reset in the middle of a read of register 0 (0x3FF).
        stream = {20'h0, 15'b0_0000_0000000000};
        bus.CS = 1'b0;
        for (int k = 14; k >= 7; k--) begin
            bus.COPI = stream[k];
            @(posedge SCK); #1;
        end
        check("mid-read CIPO", bus.CIPO, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst regs_flat", regs_flat, 60'h0);
        check("midrst err_addr", err_addr, 1'b0);
        check("midrst wr_addr", wr_addr, 4'h0);
        check("midrst CIPO", bus.CIPO, 1'b0);
        #1 rst = 1'b0;
        model_reset();
        run_frame(1'b1, 4'd3, 10'h111, rd, stb);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) ref_status[i] = 10'($urandom_range(0, 1023));
            ra = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
            run_frame(1'($urandom_range(0, 1)), ra, 10'($urandom_range(0, 1023)), rd, stb);
        end

        // Header write to addr 0 followed by two more words with CS held low.
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        @(posedge SCK); #1;
        stream = {1'b1, 4'd0, 10'h003, 10'h3FF, 10'h001};
        stb = 0;
        bus.CS = 1'b0;
        for (int k = 34; k >= 0; k--) begin
            bus.COPI = stream[k];
            @(posedge SCK); #1;
            if (wr_stb) stb++;
        end
        bus.CS = 1'b1;
        @(posedge SCK); #1;
        if (wr_stb) stb++;
        ref_regs[0] = 10'h003;
`ifdef SPI_REGBANK_BURST_EN
        ref_regs[1] = 10'h3FF;
        ref_regs[2] = 10'h001;
        check("burst wr_stb count", stb, 3);
        check("burst err_addr", err_addr, 1'b0);
        check("burst wr_addr", wr_addr, 4'd2);
`else
        // Second 15 bits decode as write to addr 15: out of range.
        check("stream wr_stb count", stb, 1);
        check("stream err_addr", err_addr, 1'b1);
        check("stream wr_addr", wr_addr, 4'd0);
`endif
        check("stream regs_flat", regs_flat, ref_flat());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_regbank_n.md
Name: spi_regbank_n

Overview:
- Parametrised SPI-slave register bank clocked directly by SCK; successor to the fixed 6×10-bit SPI register block in the buck controller.
- Adds a read/write command bit, bit-exact frame counting, readback on CIPO and per-register read-only status mapping.
- Adds write strobes to the PWM/DPWM logic and address-error reporting.
- Sits between the external SPI pins and the buck control datapath.

Parameters:
- NUM_REGS, 6: number of registers, addresses 0..NUM_REGS-1; must be ≤ 2**ADDR_W.
- ADDR_W, 4: address field width.
- DATA_W, 10: register payload width.
- RO_MASK, 'h30: bit i=1 makes register i read-only; its reads return the status_in slice.
- RST_VALUES, 0: NUM_REGS*DATA_W flat reset image; register i resets to slice i.
- FRAME_W: localparam, 1+ADDR_W+DATA_W (15 by default).

Ports:
- SCK  input  1  SPI clock; the block's only clock; all logic is posedge.
- rst  input  1  asynchronous, active-high reset.
- CS  input  1  chip select, active-low; sampled on posedge SCK.
- COPI  input  1  serial data in, MSB first.
- CIPO  output  1  serial readback data.
- status_in  input  NUM_REGS*DATA_W  live values for read-only registers.
- regs_flat  output  NUM_REGS*DATA_W  register contents; register i occupies [i*DATA_W +: DATA_W].
- wr_stb  output  1  one-SCK-cycle pulse on each committed write.
- wr_addr  output  ADDR_W  address of the last committed write.
- err_addr  output  1  sticky; set on access to address ≥ NUM_REGS or on a write to a read-only register.

Behaviour:
- Frame format, MSB first: bit1 = R/W (1 = write); next ADDR_W bits = address; last DATA_W bits = data (write data, or don't-care on a read).
- bit_cnt counts posedges while CS=0, range 0..FRAME_W-1.
- Any posedge with CS=1 clears bit_cnt and the shift register and drops any partial frame with no side effect. The host must give one CS-high SCK edge (or rst) to resync after an aborted frame.
- After a full frame with CS still low, bit_cnt wraps to 0 and the next frame needs a full header (unless SPI_REGBANK_BURST_EN is defined).
- Header latch: on the posedge capturing the last address bit (posedge 1+ADDR_W), latch rw and addr.
- Read: at the header-latch posedge, load rd_shift with the register value, or status_in for read-only registers, or 0 if the address is out of range (and set err_addr). CIPO = rd_shift MSB; rd_shift shifts left on each following posedge. The host samples data bit k on data-phase posedge k.
- CIPO = 0 outside the read data phase and whenever CS=1.
- Write: on posedge FRAME_W, data = {shift[DATA_W-2:0], COPI}.
  - Address in range and not read-only: register updates at that edge, wr_stb=1 for that cycle, wr_addr=addr.
  - Otherwise: no register change, no strobe, err_addr set.
- Write latency: the register is visible on regs_flat the same edge the last bit is sampled. There are no partial writes.
- Writes to read-only registers never change regs_flat; the read-only slice still holds its RST_VALUES slice.
- Reset: async clear of bit_cnt, shift, rd_shift, rw, addr; regs ← RST_VALUES; CIPO=0, wr_stb=0, wr_addr=0, err_addr=0. Reset mid-frame abandons the frame.
- err_addr clears only on rst.
- Simultaneous write and read are not possible; one frame is one command.

Optional Feature:
- Macro: SPI_REGBANK_BURST_EN.
- Defined (auto-increment burst): after a full frame with CS still low, each further DATA_W bits form one word for addr+1, addr+2, …, using the same rw; no new header. Each word writes or reads as above. The address wraps at 2**ADDR_W; out-of-range words set err_addr and are skipped.
- Undefined: bit_cnt wraps to 0 and the next frame needs a full header.

Test Plan:
- Reset with defaults -> regs_flat=0, CIPO=0, err_addr=0; assert rst mid-frame -> all state cleared.
- Write frame 1_0001_0101010101 -> regfile1=0x155, wr_stb pulses once on posedge 15, wr_addr=1; other registers unchanged.
- Read frame 0_0001_xxxxxxxxxx after the previous write -> CIPO emits 0101010101 on data posedges 1..10; CIPO=0 before and after.
- Write to addr 9 and to read-only addr 4 -> no register change, no wr_stb, err_addr=1 and stays 1 until rst; read of addr 4 with status_in slice=0x2AA -> CIPO emits 0x2AA.
- Abort: raise CS after 7 bits of a write, one CS-high SCK edge, then a full write of 0x0F0 to addr 2 -> only regfile2=0x0F0 changes.
- BURST_EN: header write addr 0 with data 0x003, then words 0x3FF and 0x001 -> reg0=0x003, reg1=0x3FF, reg2=0x001, three wr_stb pulses. Without the macro, the same bitstream is decoded as fresh headers.
